// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, branch flush,
// downstream hold, and a saturating count of load-use bubbles.
module id_ex_stage #(
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned RegAddrWidth = 5,
  parameter int unsigned CountWidth   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ValidID,
  input  logic                    RegWriteID,
  input  logic                    MemReadID,
  input  logic                    MemWriteID,
  input  logic                    MemToRegID,
  input  logic                    ALUSrcID,
  input  logic                    RegDstID,
  input  logic [2:0]              ALUOpID,
  input  logic                    UsesRsID,
  input  logic                    UsesRtID,
  input  logic [DataWidth-1:0]    ReadData1ID,
  input  logic [DataWidth-1:0]    ReadData2ID,
  input  logic [DataWidth-1:0]    ImmID,
  input  logic [RegAddrWidth-1:0] RsID,
  input  logic [RegAddrWidth-1:0] RtID,
  input  logic [RegAddrWidth-1:0] RdID,
  input  logic                    FlushEX,
  input  logic                    HoldEX,
  output logic                    ValidID2EX,
  output logic                    RegWriteID2EX,
  output logic                    MemReadID2EX,
  output logic                    MemWriteID2EX,
  output logic                    MemToRegID2EX,
  output logic                    ALUSrcID2EX,
  output logic                    RegDstID2EX,
  output logic [2:0]              ALUOpID2EX,
  output logic [DataWidth-1:0]    ReadData1ID2EX,
  output logic [DataWidth-1:0]    ReadData2ID2EX,
  output logic [DataWidth-1:0]    ImmID2EX,
  output logic [RegAddrWidth-1:0] RsID2EX,
  output logic [RegAddrWidth-1:0] RtID2EX,
  output logic [RegAddrWidth-1:0] RdID2EX,
  output logic                    PCWrite,
  output logic                    IFIDWrite,
  output logic [CountWidth-1:0]   StallCount
);

  typedef struct packed {
    logic                    valid;
    logic                    reg_write;
    logic                    mem_read;
    logic                    mem_write;
    logic                    mem_to_reg;
    logic                    alu_src;
    logic                    reg_dst;
    logic [2:0]              alu_op;
    logic [DataWidth-1:0]    read_data1;
    logic [DataWidth-1:0]    read_data2;
    logic [DataWidth-1:0]    imm;
    logic [RegAddrWidth-1:0] rs;
    logic [RegAddrWidth-1:0] rt;
    logic [RegAddrWidth-1:0] rd;
  } stage_t;

  stage_t                  stage_in;
  stage_t                  stage_d, stage_q;
  logic [CountWidth-1:0]   stall_cnt_d, stall_cnt_q;
  logic                    load_use;

  always_comb begin
    stage_in.valid      = ValidID;
    stage_in.reg_write  = RegWriteID;
    stage_in.mem_read   = MemReadID;
    stage_in.mem_write  = MemWriteID;
    stage_in.mem_to_reg = MemToRegID;
    stage_in.alu_src    = ALUSrcID;
    stage_in.reg_dst    = RegDstID;
    stage_in.alu_op     = ALUOpID;
    stage_in.read_data1 = ReadData1ID;
    stage_in.read_data2 = ReadData2ID;
    stage_in.imm        = ImmID;
    stage_in.rs         = RsID;
    stage_in.rt         = RtID;
    stage_in.rd         = RdID;
  end

  // Only registered state and ID inputs feed this, so no loop through EX.
  always_comb begin
    load_use = stage_q.valid && stage_q.mem_read && (stage_q.rt != '0) && ValidID &&
               ((UsesRsID && (RsID == stage_q.rt)) || (UsesRtID && (RtID == stage_q.rt)));
  end

  always_comb begin
    stage_d     = stage_q;
    stall_cnt_d = stall_cnt_q;
    if (!HoldEX) begin
      if (FlushEX) begin
        stage_d = '0;
      end else if (load_use) begin
        stage_d = '0;
        if (stall_cnt_q != '1) begin
          stall_cnt_d = stall_cnt_q + CountWidth'(1);
        end
      end else begin
        stage_d = stage_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      stage_q     <= stage_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    PCWrite        = ~(HoldEX | (load_use & ~FlushEX));
    IFIDWrite      = PCWrite;
    StallCount     = stall_cnt_q;
    ValidID2EX     = stage_q.valid;
    RegWriteID2EX  = stage_q.reg_write;
    MemReadID2EX   = stage_q.mem_read;
    MemWriteID2EX  = stage_q.mem_write;
    MemToRegID2EX  = stage_q.mem_to_reg;
    ALUSrcID2EX    = stage_q.alu_src;
    RegDstID2EX    = stage_q.reg_dst;
    ALUOpID2EX     = stage_q.alu_op;
    ReadData1ID2EX = stage_q.read_data1;
    ReadData2ID2EX = stage_q.read_data2;
    ImmID2EX       = stage_q.imm;
    RsID2EX        = stage_q.rs;
    RtID2EX        = stage_q.rt;
    RdID2EX        = stage_q.rd;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register for the five-stage MIPS core, with integrated load-use hazard detection. It captures decoded control, operands and register specifiers from ID and presents them to EX, including the RsID2EX/RtID2EX values consumed by the forwarding unit. It inserts a one-cycle bubble on a load-use dependency, flushes on a taken branch, and freezes on a downstream memory hold. It also keeps a saturating count of load-use stall cycles.

## Interface
Parameters:
- DataWidth, 32, width of operand and immediate datapaths
- RegAddrWidth, 5, register specifier width
- CountWidth, 16, width of StallCount

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- ValidID  in  1  ID holds a real instruction
- RegWriteID, MemReadID, MemWriteID, MemToRegID, ALUSrcID, RegDstID  in  1 each  decoded control
- ALUOpID  in  3  ALU operation class
- UsesRsID, UsesRtID  in  1 each  ID instruction reads Rs / Rt as a source
- ReadData1ID, ReadData2ID, ImmID  in  DataWidth each  register-file reads and sign-extended immediate
- RsID, RtID, RdID  in  RegAddrWidth each  register specifiers
- FlushEX  in  1  taken branch or jump resolved in EX; squash the ID instruction
- HoldEX  in  1  downstream stall; freeze this stage
- All ID2EX outputs (same names with the ID2EX suffix, same widths, plus ValidID2EX)  out  registered copies
- PCWrite  out  1  PC may advance
- IFIDWrite  out  1  IF/ID register may load
- StallCount  out  CountWidth  load-use bubble cycles since reset, saturating

## Operation
- LoadUse (combinational) = ValidID2EX & MemReadID2EX & RtID2EX≠0 & ValidID & ((UsesRsID & RsID==RtID2EX) | (UsesRtID & RtID==RtID2EX)).
- Per-edge action, in priority order:
  1. Reset: all ID2EX registers cleared to 0, including ValidID2EX. StallCount is cleared to 0.
  2. HoldEX=1: all registers keep their values. FlushEX is ignored; the branch unit re-asserts it after the hold. StallCount keeps its value.
  3. FlushEX=1: bubble. ValidID2EX and all control bits (RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, RegDst, ALUOp) load 0. Data and specifier registers load 0.
  4. LoadUse=1: bubble, exactly as for FlushEX. StallCount increments unless it already equals all-ones.
  5. Otherwise: every ID2EX register loads its ID input.
- PCWrite = IFIDWrite = ~(HoldEX | (LoadUse & ~FlushEX)). FlushEX takes precedence over LoadUse, because the dependent instruction is being squashed anyway.
- A bubble clears every specifier register. RsID2EX, RtID2EX and RdID2EX are therefore 0 during a bubble, so the forwarding unit sees register 0 and never forwards.
- The $zero register never triggers a stall (RtID2EX≠0 term).
- The LoadUse condition references only registered state and ID inputs. It produces no combinational loop through the EX stage.

## Timing
- Latency: 1 cycle from the ID inputs to the ID2EX outputs.
- Reset values: every ID2EX output is 0 and StallCount is 0. PCWrite and IFIDWrite are 1 while rst_n is low, provided HoldEX=0; this follows from the equation above because ValidID2EX=0.
- Load-use stall lasts exactly 1 cycle:
  - Cycle N: load in ID2EX, dependent instruction in ID. PCWrite=0, IFIDWrite=0.
  - Edge N+1: bubble enters ID2EX.
  - Cycle N+1: LoadUse=0, because MemReadID2EX=0.
  - Edge N+2: dependent instruction enters EX; the load value is forwarded from MEM/WB.
- Back-to-back loads with a dependency each cause their own single bubble. StallCount counts each bubble once.
- Reset asserted mid-stall: the next edge clears all state. No residual stall follows.
- HoldEX asserted during a LoadUse cycle: the stage freezes and the counter is not incremented. The bubble and the increment occur on the first edge after HoldEX deasserts, if LoadUse is still true.
- StallCount saturates at 2^CountWidth−1. Further bubbles leave it unchanged.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with random inputs. Check all ID2EX outputs = 0, StallCount = 0, PCWrite = 1, IFIDWrite = 1.
- Pass-through: ValidID=1, RsID=3, RtID=4, RdID=5, ReadData1ID=0x1234, ALUOpID=2, no hazards. One cycle later, check ID2EX outputs equal exactly these values.
- Load-use: put lw $2 into ID2EX (MemRead=1, Rt=2), then ID holds add with Rs=2 and UsesRsID=1. Check PCWrite=0 for one cycle, a bubble enters (ValidID2EX=0, RsID2EX=0), and StallCount = 1. Next cycle: the add enters with RsID2EX=2.
- No false stall:
  - Load with Rt=0 and ID Rs=0 → no stall.
  - Load Rt=7, ID Rt=7 with UsesRtID=0 → no stall, StallCount unchanged.
- Flush vs LoadUse vs Hold:
  - FlushEX and LoadUse together → bubble, PCWrite=1, StallCount unchanged.
  - HoldEX=1 with FlushEX=1 → outputs frozen, PCWrite=0.
- Saturation: with CountWidth=4, force 17 load-use bubbles. Check StallCount stays at 15.
